// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  // FSM encoding: idle/arbitrating, fetch owns the memory, load/store owns the memory.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_IF = 2'd1,
    ARB_GNT_LS = 2'd2
  } arb_state_e;

  // Byte-enable width and the read mask at the default 32-bit data width.
  localparam int ARB_DATA_W = 32;
  localparam int BMASK_W    = ARB_DATA_W / 8;
  localparam logic [BMASK_W-1:0] BMASK_ALL = '1;

  // Starvation counter width; STARVE_MAX is limited to 1..15.
  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of load/store grants taken while fetch was waiting.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o,
  output logic lt_o
);

  localparam logic [STARVE_W-1:0] MAX_C = STARVE_W'(MAX);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  // Clear has priority over increment; increment stops at MAX.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q < MAX_C)) begin
      cnt_d = cnt_q + STARVE_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lt_o  = (cnt_q < MAX_C);
  assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store access to one single-port memory.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no access in flight; arbitrate (except in an ack cycle)
// ARB_GNT_IF | fetch read issued; waiting for i_mem_ack or watchdog
// ARB_GNT_LS | load/store issued; waiting for i_mem_ack or watchdog
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_if_req,
  input  logic [ADDR_W-1:0]     i_if_addr,
  output logic                  o_if_ack,
  output logic [DATA_W-1:0]     o_if_rdata,
  output logic                  o_if_stall,
  input  logic                  i_ls_req,
  input  logic                  i_ls_wren,
  input  logic [ADDR_W-1:0]     i_ls_addr,
  input  logic [DATA_W-1:0]     i_ls_wdata,
  input  logic [DATA_W/8-1:0]   i_ls_bmask,
  output logic                  o_ls_ack,
  output logic [DATA_W-1:0]     o_ls_rdata,
  output logic                  o_ls_stall,
  output logic                  o_mem_req,
  output logic                  o_mem_wren,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_bmask,
  input  logic                  i_mem_ack,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic                  o_err,
  output logic                  o_busy
);

  localparam int  BMW    = DATA_W / 8;
  localparam bit  TMO_EN = (TIMEOUT > 0);
  localparam int  TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_wren_q, mem_wren_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BMW-1:0]    mem_bmask_q, mem_bmask_d;
  logic              if_ack_q, if_ack_d;
  logic              ls_ack_q, ls_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic              grant_if, grant_ls;
  logic              starve_lt, starve_sat;
  logic              ls_win;
  logic              done, abort;
  logic [BMW-1:0]    bmask_all;

  // Reuse the package read mask when the data width matches its default.
  if (BMW == BMASK_W) begin : g_pkg_mask
    assign bmask_all = BMASK_ALL;
  end else begin : g_wide_mask
    assign bmask_all = '1;
  end

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .inc_i  (grant_ls & i_if_req),
    .clr_i  (grant_if),
    .sat_o  (starve_sat),
    .lt_o   (starve_lt)
  );

  // Load/store has priority until fetch has waited through STARVE_MAX grants.
  assign ls_win = i_ls_req & (~i_if_req | starve_lt);

  // Next-state, grant latching, completion and watchdog abort.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_wren_d  = mem_wren_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bmask_d = mem_bmask_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    err_d       = 1'b0;
    tmo_d       = tmo_q;
    grant_if    = 1'b0;
    grant_ls    = 1'b0;
    done        = 1'b0;
    abort       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // The ack cycle is the mandatory gap: the acked requester still
        // shows its request here and must not be granted again.
        if (!(if_ack_q || ls_ack_q)) begin
          if (ls_win) begin
            grant_ls    = 1'b1;
            state_d     = ARB_GNT_LS;
            mem_req_d   = 1'b1;
            mem_wren_d  = i_ls_wren;
            mem_addr_d  = i_ls_addr;
            mem_wdata_d = i_ls_wdata;
            mem_bmask_d = i_ls_wren ? i_ls_bmask : bmask_all;
            tmo_d       = '0;
          end else if (i_if_req) begin
            grant_if    = 1'b1;
            state_d     = ARB_GNT_IF;
            mem_req_d   = 1'b1;
            mem_wren_d  = 1'b0;
            mem_addr_d  = i_if_addr;
            mem_wdata_d = '0;
            mem_bmask_d = bmask_all;
            tmo_d       = '0;
          end
        end
      end
      ARB_GNT_IF, ARB_GNT_LS: begin
        if (TMO_EN) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
        if (i_mem_ack) begin
          done = 1'b1;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          done  = 1'b1;
          abort = 1'b1;
        end
        if (done) begin
          state_d   = ARB_IDLE;
          mem_req_d = 1'b0;
          err_d     = abort;
          if (state_q == ARB_GNT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = abort ? '0 : i_mem_rdata;
          end else begin
            ls_ack_d   = 1'b1;
            ls_rdata_d = (abort || mem_wren_q) ? '0 : i_mem_rdata;
          end
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any access without an ack.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ARB_IDLE;
      mem_req_q   <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bmask_q <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      err_q       <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign o_if_ack    = if_ack_q;
  assign o_if_rdata  = if_rdata_q;
  assign o_if_stall  = i_if_req & ~if_ack_q;
  assign o_ls_ack    = ls_ack_q;
  assign o_ls_rdata  = ls_rdata_q;
  assign o_ls_stall  = i_ls_req & ~ls_ack_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_wren  = mem_wren_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;
  assign o_err       = err_q;
  assign o_busy      = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_MAX=4, TIMEOUT=8).
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        ls_req;
  logic        ls_wren;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_bmask;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        ls_stall;
  logic        mem_req;
  logic        mem_wren;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bmask;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (4),
    .TIMEOUT    (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_ack    (if_ack),
    .o_if_rdata  (if_rdata),
    .o_if_stall  (if_stall),
    .i_ls_req    (ls_req),
    .i_ls_wren   (ls_wren),
    .i_ls_addr   (ls_addr),
    .i_ls_wdata  (ls_wdata),
    .i_ls_bmask  (ls_bmask),
    .o_ls_ack    (ls_ack),
    .o_ls_rdata  (ls_rdata),
    .o_ls_stall  (ls_stall),
    .o_mem_req   (mem_req),
    .o_mem_wren  (mem_wren),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_bmask (mem_bmask),
    .i_mem_ack   (mem_ack),
    .i_mem_rdata (mem_rdata),
    .o_err       (err),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory acks in the current cycle; returns just after the edge that consumes it.
  task automatic mem_ack_now(input logic [31:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wren = 1'b0;
    ls_addr = '0; ls_wdata = '0; ls_bmask = '0; mem_ack = 1'b0; mem_rdata = '0;
    #22;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_ls_ack", ls_ack, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_ls_rdata", ls_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_bmask", mem_bmask, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // Stray memory ack while idle does nothing.
    mem_ack_now(32'h1111_2222);
    chk("idle_ack_if", if_ack, 0);
    chk("idle_ack_ls", ls_ack, 0);
    chk("idle_ack_busy", busy, 0);

    // Fetch only, memory acks in the second req cycle.
    if_req = 1'b1; if_addr = 32'h0000_0010;
    tick();
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h10);
    chk("f_mem_wren", mem_wren, 0);
    chk("f_mem_bmask", mem_bmask, 4'hF);
    chk("f_busy", busy, 1);
    chk("f_stall", if_stall, 1);
    tick();
    chk("f_no_early_ack", if_ack, 0);
    mem_ack_now(32'h0051_3023);
    chk("f_if_ack", if_ack, 1);
    chk("f_if_rdata", if_rdata, 32'h0051_3023);
    chk("f_mem_req_drop", mem_req, 0);
    chk("f_stall_ack", if_stall, 0);
    if_req = 1'b0;
    tick();
    chk("f_ack_one_cycle", if_ack, 0);
    chk("f_stall_after", if_stall, 0);

    // Simultaneous fetch and load: load first, then fetch after one idle cycle.
    if_req = 1'b1; if_addr = 32'h20;
    ls_req = 1'b1; ls_wren = 1'b0; ls_addr = 32'h100;
    tick();
    chk("s_ls_first_addr", mem_addr, 32'h100);
    chk("s_if_stall", if_stall, 1);
    chk("s_ls_stall", ls_stall, 1);
    chk("s_starve1", dut.u_starve.cnt_q, 1);
    mem_ack_now(32'hCAFE_0001);
    chk("s_ls_ack", ls_ack, 1);
    chk("s_ls_rdata", ls_rdata, 32'hCAFE_0001);
    chk("s_if_no_ack", if_ack, 0);
    ls_req = 1'b0;
    tick();
    chk("s_gap_idle", mem_req, 0);
    chk("s_gap_busy", busy, 0);
    tick();
    chk("s_if_grant", mem_req, 1);
    chk("s_if_addr", mem_addr, 32'h20);
    chk("s_starve_clr", dut.u_starve.cnt_q, 0);
    mem_ack_now(32'h0000_1234);
    chk("s_if_ack", if_ack, 1);
    chk("s_if_rdata", if_rdata, 32'h1234);
    if_req = 1'b0;
    tick();

    // Continuous loads with fetch held: four load grants, then fetch.
    if_req = 1'b1; if_addr = 32'h30;
    ls_req = 1'b1; ls_wren = 1'b0; ls_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("st_ls_grant_addr", mem_addr, 32'h40);
      mem_ack_now(32'h100 + 32'(i));
      chk("st_ls_ack", ls_ack, 1);
      chk("st_ls_rdata", ls_rdata, 32'h100 + 32'(i));
      tick();
    end
    chk("st_cnt_sat", dut.u_starve.cnt_q, 4);
    tick();
    chk("st_if_grant_addr", mem_addr, 32'h30);
    chk("st_cnt_clr", dut.u_starve.cnt_q, 0);
    chk("st_ls_waits", ls_stall, 1);
    mem_ack_now(32'h0BAD_F00D);
    chk("st_if_ack", if_ack, 1);
    chk("st_if_rdata", if_rdata, 32'h0BAD_F00D);
    if_req = 1'b0; ls_req = 1'b0;
    tick();

    // Store: fields latched at grant, rdata zero on ack.
    ls_req = 1'b1; ls_wren = 1'b1; ls_addr = 32'h200;
    ls_wdata = 32'hDEAD_BEEF; ls_bmask = 4'b0011;
    tick();
    chk("w_wren", mem_wren, 1);
    chk("w_addr", mem_addr, 32'h200);
    chk("w_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("w_bmask", mem_bmask, 4'b0011);
    ls_wdata = 32'h0; ls_bmask = 4'hF; ls_addr = 32'h999;
    tick();
    tick();
    chk("w_hold_req", mem_req, 1);
    chk("w_hold_bmask", mem_bmask, 4'b0011);
    chk("w_hold_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("w_hold_addr", mem_addr, 32'h200);
    mem_ack_now(32'h1234_5678);
    chk("w_ls_ack", ls_ack, 1);
    chk("w_ls_rdata", ls_rdata, 0);
    chk("w_err", err, 0);
    ls_req = 1'b0; ls_wren = 1'b0;
    tick();

    // Load that never gets an ack: abort after 8 req cycles.
    ls_req = 1'b1; ls_addr = 32'h300; mem_rdata = 32'hFFFF_FFFF;
    tick();
    chk("t_req_start", mem_req, 1);
    chk("t_load_bmask", mem_bmask, 4'hF);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t_req_held", mem_req, 1);
      chk("t_no_ack_yet", ls_ack, 0);
    end
    tick();
    chk("t_req_drop", mem_req, 0);
    chk("t_ls_ack", ls_ack, 1);
    chk("t_err", err, 1);
    chk("t_rdata", ls_rdata, 0);
    ls_req = 1'b0;
    tick();
    chk("t_err_pulse", err, 0);
    chk("t_ack_pulse", ls_ack, 0);

    // Next load served normally.
    ls_req = 1'b1; ls_addr = 32'h304;
    tick();
    mem_ack_now(32'hA5A5_A5A5);
    chk("t2_ack", ls_ack, 1);
    chk("t2_err", err, 0);
    chk("t2_rdata", ls_rdata, 32'hA5A5_A5A5);
    ls_req = 1'b0;
    tick();

    // Ack arriving in the timeout cycle wins.
    ls_req = 1'b1; ls_addr = 32'h308;
    tick();
    for (int i = 0; i < 7; i++) tick();
    mem_ack_now(32'h0000_0011);
    chk("tb_ack", ls_ack, 1);
    chk("tb_err", err, 0);
    chk("tb_rdata", ls_rdata, 32'h11);
    ls_req = 1'b0;
    tick();

    // Reset during a fetch grant.
    if_req = 1'b1; if_addr = 32'h50;
    tick();
    chk("r_granted", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_mem_req", mem_req, 0);
    chk("r_busy", busy, 0);
    chk("r_if_ack", if_ack, 0);
    chk("r_ls_ack", ls_ack, 0);
    if_req = 1'b0;
    #2;
    rst_n = 1'b1;
    mem_ack_now(32'h0000_0066);
    chk("r_no_ack_a", if_ack, 0);
    tick();
    chk("r_no_ack_b", if_ack, 0);
    chk("r_idle", busy, 0);
    if_req = 1'b1; if_addr = 32'h60;
    tick();
    chk("r_fresh_addr", mem_addr, 32'h60);
    mem_ack_now(32'h0000_0077);
    chk("r_fresh_ack", if_ack, 1);
    chk("r_fresh_rdata", if_rdata, 32'h77);
    if_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
